// File: rtl/decn_sweep_pkg.sv
// rtl/decn_sweep_pkg.sv - shared states, sweep bounds and one-hot helper for decn_sweep
package decn_sweep_pkg;

   localparam int MAX_N = 6;
   localparam int MAX_W = 64;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SWEEP = 2'd1,
      ST_FIN   = 2'd2
   } state_t;

   function automatic int first_idx(input int skip0);
      return (skip0 != 0) ? 1 : 0;
   endfunction

   function automatic int last_idx(input int n);
      return (1 << n) - 1;
   endfunction

   // Indices at or beyond width yield all-zero, so callers can truncate safely.
   function automatic logic [MAX_W-1:0] onehot(input logic [MAX_N-1:0] index, input int width);
      logic [MAX_W-1:0] r;
      r = '0;
      if (int'(index) < width) r[index] = 1'b1;
      return r;
   endfunction

endpackage

// File: rtl/decn_sweep_if.sv
// rtl/decn_sweep_if.sv - request/enable bundle between the write pipeline and decn_sweep
interface decn_sweep_if #(parameter int N = 5);

   logic [N-1:0]      n;
   logic              ena;
   logic              start;
   logic [2**N-1:0]   e;
   logic [N-1:0]      idx;
   logic              ready;
   logic              busy;
   logic              done;

   modport master (output n, ena, start, input e, idx, ready, busy, done);
   modport slave  (input n, ena, start, output e, idx, ready, busy, done);

endinterface

// File: rtl/decn_sweep_decn.sv
// rtl/decn_sweep_decn.sv - combinational N-to-2^N decoder with enable
module decn
   import decn_sweep_pkg::*;
#(
   parameter int N = 5
) (
   input  logic [N-1:0]    i_addr,
   input  logic            i_en,
   output logic [2**N-1:0] o_dec
);

   localparam int W = 2**N;

   assign o_dec = i_en ? W'(onehot(MAX_N'(i_addr), W)) : '0;

endmodule

// File: rtl/decn_sweep.sv
// rtl/decn_sweep.sv - registered one-hot write-enable generator with initialisation sweep
module decn_sweep
   import decn_sweep_pkg::*;
#(
   parameter int N              = 5,
   parameter int SKIP0          = 1,
   parameter int SWEEP_ON_RESET = 1
) (
   input  logic         i_clk,
   input  logic         i_clrn,
   decn_sweep_if.slave  bus
);

   localparam int           W         = 2**N;
   localparam logic [N-1:0] FIRST     = N'(first_idx(SKIP0));
   localparam logic [N-1:0] LAST      = N'(last_idx(N));
   localparam state_t       RST_STATE = (SWEEP_ON_RESET != 0) ? ST_SWEEP : ST_IDLE;

   state_t         r_state, w_state_nxt;
   logic [N-1:0]   r_cnt, w_cnt_nxt;
   logic [N-1:0]   r_idx, w_idx_nxt;
   logic [N-1:0]   w_addr;
   logic [W-1:0]   r_e, w_dec;
   logic           r_done, w_done_nxt;
   logic           w_dec_en;

   // start wins over a same-cycle direct write; the sweep compares before incrementing so cnt never wraps
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_done_nxt  = 1'b0;
      w_addr      = bus.n;
      w_dec_en    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (bus.start) begin
               w_state_nxt = ST_SWEEP;
               w_cnt_nxt   = FIRST;
            end else begin
               w_dec_en = bus.ena;
            end
         end
         ST_SWEEP: begin
            w_addr   = r_cnt;
            w_dec_en = 1'b1;
            if (r_cnt == LAST) w_state_nxt = ST_FIN;
            else               w_cnt_nxt   = r_cnt + 1'b1;
         end
         ST_FIN: begin
            w_done_nxt  = 1'b1;
            w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
      w_idx_nxt = w_dec_en ? w_addr : '0;
   end

   decn #(.N(N)) u_decn (
      .i_addr (w_addr),
      .i_en   (w_dec_en),
      .o_dec  (w_dec)
   );

   always_ff @(posedge i_clk or negedge i_clrn) begin
      if (!i_clrn) begin
         r_state <= RST_STATE;
         r_cnt   <= FIRST;
         r_e     <= '0;
         r_idx   <= '0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_e     <= w_dec;
         r_idx   <= w_idx_nxt;
         r_done  <= w_done_nxt;
      end
   end

   assign bus.e     = r_e;
   assign bus.idx   = r_idx;
   assign bus.done  = r_done;
   assign bus.ready = (r_state == ST_IDLE);
   assign bus.busy  = (r_state != ST_IDLE);

endmodule

// File: tb/tb_decn_sweep.sv
// tb/tb_decn_sweep.sv - directed self-checking bench for decn_sweep
module tb_decn_sweep;

   logic clk;
   logic clrn_a;
   logic clrn_b;
   int   n_checks;
   int   n_fails;

   decn_sweep_if #(.N(5)) ia ();
   decn_sweep_if #(.N(3)) ib ();

   decn_sweep #(.N(5), .SKIP0(1), .SWEEP_ON_RESET(1)) u_a (
      .i_clk  (clk),
      .i_clrn (clrn_a),
      .bus    (ia)
   );

   decn_sweep #(.N(3), .SKIP0(0), .SWEEP_ON_RESET(0)) u_b (
      .i_clk  (clk),
      .i_clrn (clrn_b),
      .bus    (ib)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [63:0] one;
      one      = 64'd1;
      n_checks = 0;
      n_fails  = 0;
      clrn_a   = 1'b0;
      clrn_b   = 1'b0;
      ia.n = '0; ia.ena = 1'b0; ia.start = 1'b0;
      ib.n = '0; ib.ena = 1'b0; ib.start = 1'b0;
      step(); step();

      check("a_rst_e",     ia.e,     0);
      check("a_rst_idx",   ia.idx,   0);
      check("a_rst_busy",  ia.busy,  1);
      check("a_rst_ready", ia.ready, 0);
      check("a_rst_done",  ia.done,  0);
      check("b_rst_ready", ib.ready, 1);
      check("b_rst_busy",  ib.busy,  0);
      check("b_rst_e",     ib.e,     0);

      // auto sweep after release, with inputs wiggling to prove they are ignored
      clrn_a = 1'b1;
      clrn_b = 1'b1;
      check("a_rel_busy", ia.busy, 1);
      for (int i = 1; i <= 31; i++) begin
         ia.ena   = i[0];
         ia.n     = 5'(i);
         ia.start = i[1];
         step();
         check($sformatf("a_auto_e%0d", i),   ia.e,     one << i);
         check($sformatf("a_auto_idx%0d", i), ia.idx,   64'(i));
         check($sformatf("a_auto_rdy%0d", i), ia.ready, 0);
      end
      ia.ena = 1'b1; ia.start = 1'b1;
      step();
      check("a_fin_e",     ia.e,     0);
      check("a_fin_done",  ia.done,  1);
      check("a_fin_busy",  ia.busy,  0);
      check("a_fin_ready", ia.ready, 1);
      ia.ena = 1'b0; ia.start = 1'b0;
      step();
      check("a_done_clr", ia.done, 0);
      check("a_idle_e",   ia.e,    0);

      // direct mode
      ia.n = 5'd7; ia.ena = 1'b1;
      step();
      check("a_dir7_e",   ia.e,   64'h80);
      check("a_dir7_idx", ia.idx, 7);
      ia.n = 5'd0;
      step();
      check("a_dir0_e", ia.e, 64'h1);
      ia.n = 5'd31;
      step();
      check("a_dir31_e",   ia.e,   64'h8000_0000);
      check("a_dir31_idx", ia.idx, 31);
      ia.ena = 1'b0;
      step();
      check("a_noena_e",   ia.e,   0);
      check("a_noena_idx", ia.idx, 0);

      // start and ena together: start wins
      ia.start = 1'b1; ia.ena = 1'b1; ia.n = 5'd3;
      step();
      check("a_st_e",    ia.e,    0);
      check("a_st_idx",  ia.idx,  0);
      check("a_st_busy", ia.busy, 1);
      ia.start = 1'b0; ia.ena = 1'b0;
      for (int i = 1; i <= 16; i++) begin
         step();
         check($sformatf("a_sw_e%0d", i), ia.e, one << i);
      end

      // async reset mid-sweep
      clrn_a = 1'b0;
      #1;
      check("a_mid_rst_e",    ia.e,    0);
      check("a_mid_rst_busy", ia.busy, 1);
      #2;
      clrn_a = 1'b1;
      for (int i = 1; i <= 31; i++) begin
         step();
         check($sformatf("a_re_e%0d", i), ia.e, one << i);
      end
      step();
      check("a_re_done", ia.done, 1);

      // start during the done cycle begins a fresh sweep
      ia.start = 1'b1;
      step();
      check("a_dc_e",    ia.e,    0);
      check("a_dc_busy", ia.busy, 1);
      check("a_dc_done", ia.done, 0);
      ia.start = 1'b0;
      step();
      check("a_dc_first", ia.e, 64'h2);

      // N=3, SKIP0=0, manual start
      check("b_idle_ready", ib.ready, 1);
      ib.start = 1'b1;
      step();
      check("b_st_e",    ib.e,    0);
      check("b_st_busy", ib.busy, 1);
      ib.start = 1'b0;
      for (int i = 0; i <= 7; i++) begin
         step();
         check($sformatf("b_sw_e%0d", i),   ib.e,   one << i);
         check($sformatf("b_sw_idx%0d", i), ib.idx, 64'(i));
      end
      step();
      check("b_fin_e",     ib.e,     0);
      check("b_fin_done",  ib.done,  1);
      check("b_fin_ready", ib.ready, 1);
      step();
      check("b_done_clr", ib.done, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
